// File: rtl/ahb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ahb_ram_arbiter
// Brief   : Two-master AHB-Lite arbiter (M0 fetch, M1 load/store) in front of
//           one RAM slave; losing address phases are pended and replayed.
// Revision: 1.0 - initial release
// ============================================================================
module ahb_ram_arbiter #(
  parameter int ARB_MODE = 1,
  parameter int AW       = 32
) (
  input  logic          hclk,
  input  logic          hreset,
  input  logic          m0_hsel,
  input  logic [1:0]    m0_htrans,
  input  logic          m0_hwrite,
  input  logic [2:0]    m0_hsize,
  input  logic [AW-1:0] m0_haddr,
  input  logic [31:0]   m0_hwdata,
  output logic [31:0]   m0_hrdata,
  output logic          m0_hready,
  output logic [1:0]    m0_hresp,
  input  logic          m1_hsel,
  input  logic [1:0]    m1_htrans,
  input  logic          m1_hwrite,
  input  logic [2:0]    m1_hsize,
  input  logic [AW-1:0] m1_haddr,
  input  logic [31:0]   m1_hwdata,
  output logic [31:0]   m1_hrdata,
  output logic          m1_hready,
  output logic [1:0]    m1_hresp,
  output logic          s_hsel,
  output logic [1:0]    s_htrans,
  output logic          s_hwrite,
  output logic [2:0]    s_hsize,
  output logic [AW-1:0] s_haddr,
  output logic [31:0]   s_hwdata,
  output logic          s_hready_in,
  input  logic [31:0]   s_hrdata,
  input  logic          s_hready_out,
  input  logic [1:0]    s_hresp
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } own_t;

  own_t          own, own_next;
  logic          rr_last, rr_last_next;   // 0 = M0 granted last, 1 = M1
  logic          pend0, pend1;
  logic          pend0_hwrite, pend1_hwrite;
  logic [2:0]    pend0_hsize, pend1_hsize;
  logic [AW-1:0] pend0_haddr, pend1_haddr;

  logic          hold_hsel, hold_hwrite;
  logic [1:0]    hold_htrans;
  logic [2:0]    hold_hsize;
  logic [AW-1:0] hold_haddr;

  logic          req0, req1, cand0, cand1, grant0, grant1;
  logic          win_hsel, win_hwrite;
  logic [1:0]    win_htrans;
  logic [2:0]    win_hsize;
  logic [AW-1:0] win_haddr;

  assign m0_hready = (own == OWN_M0) ? s_hready_out : ~pend0;
  assign m1_hready = (own == OWN_M1) ? s_hready_out : ~pend1;
  assign m0_hresp  = (own == OWN_M0) ? s_hresp : 2'b00;
  assign m1_hresp  = (own == OWN_M1) ? s_hresp : 2'b00;
  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;
  assign s_hready_in = s_hready_out;

  always_comb begin
    req0   = m0_hsel & m0_htrans[1] & m0_hready;
    req1   = m1_hsel & m1_htrans[1] & m1_hready;
    cand0  = pend0 | req0;
    cand1  = pend1 | req1;
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (s_hready_out) begin
      if (cand0 && cand1) begin
        if (ARB_MODE == 0) grant1 = 1'b1;
        else if (rr_last)  grant0 = 1'b1;
        else               grant1 = 1'b1;
      end else begin
        grant0 = cand0;
        grant1 = cand1;
      end
    end
  end

  // Replayed transfers are always presented as NONSEQ: the burst context is lost.
  always_comb begin
    win_hsel   = 1'b0;
    win_htrans = 2'b00;
    win_hwrite = 1'b0;
    win_hsize  = 3'b000;
    win_haddr  = '0;
    if (grant0) begin
      win_hsel = 1'b1;
      if (pend0) begin
        win_htrans = 2'b10;
        win_hwrite = pend0_hwrite;
        win_hsize  = pend0_hsize;
        win_haddr  = pend0_haddr;
      end else begin
        win_htrans = m0_htrans;
        win_hwrite = m0_hwrite;
        win_hsize  = m0_hsize;
        win_haddr  = m0_haddr;
      end
    end else if (grant1) begin
      win_hsel = 1'b1;
      if (pend1) begin
        win_htrans = 2'b10;
        win_hwrite = pend1_hwrite;
        win_hsize  = pend1_hsize;
        win_haddr  = pend1_haddr;
      end else begin
        win_htrans = m1_htrans;
        win_hwrite = m1_hwrite;
        win_hsize  = m1_hsize;
        win_haddr  = m1_haddr;
      end
    end
  end

  always_comb begin
    s_hsel   = s_hready_out ? win_hsel   : hold_hsel;
    s_htrans = s_hready_out ? win_htrans : hold_htrans;
    s_hwrite = s_hready_out ? win_hwrite : hold_hwrite;
    s_hsize  = s_hready_out ? win_hsize  : hold_hsize;
    s_haddr  = s_hready_out ? win_haddr  : hold_haddr;
    case (own)
      OWN_M0:  s_hwdata = m0_hwdata;
      OWN_M1:  s_hwdata = m1_hwdata;
      default: s_hwdata = 32'h0;
    endcase
  end

  always_comb begin
    own_next     = own;
    rr_last_next = rr_last;
    if (s_hready_out) begin
      if (grant0) begin
        own_next     = OWN_M0;
        rr_last_next = 1'b0;
      end else if (grant1) begin
        own_next     = OWN_M1;
        rr_last_next = 1'b1;
      end else begin
        own_next     = OWN_NONE;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      own     <= OWN_NONE;
      rr_last <= 1'b1;
    end else begin
      own     <= own_next;
      rr_last <= rr_last_next;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      pend0        <= 1'b0;
      pend1        <= 1'b0;
      pend0_hwrite <= 1'b0;
      pend1_hwrite <= 1'b0;
      pend0_hsize  <= 3'b000;
      pend1_hsize  <= 3'b000;
      pend0_haddr  <= '0;
      pend1_haddr  <= '0;
      hold_hsel    <= 1'b0;
      hold_htrans  <= 2'b00;
      hold_hwrite  <= 1'b0;
      hold_hsize   <= 3'b000;
      hold_haddr   <= '0;
    end else begin
      if (s_hready_out) begin
        hold_hsel   <= win_hsel;
        hold_htrans <= win_htrans;
        hold_hwrite <= win_hwrite;
        hold_hsize  <= win_hsize;
        hold_haddr  <= win_haddr;
      end
      // A live request that is not granted this cycle (lost or slave busy) is pended.
      if (grant0) begin
        pend0 <= 1'b0;
      end else if (req0) begin
        pend0        <= 1'b1;
        pend0_hwrite <= m0_hwrite;
        pend0_hsize  <= m0_hsize;
        pend0_haddr  <= m0_haddr;
      end
      if (grant1) begin
        pend1 <= 1'b0;
      end else if (req1) begin
        pend1        <= 1'b1;
        pend1_hwrite <= m1_hwrite;
        pend1_hsize  <= m1_hsize;
        pend1_haddr  <= m1_haddr;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ahb_ram_arbiter
// Brief   : Self-checking bench; instance 0 is fixed priority, instance 1 is
//           round-robin, each backed by a small RAM slave model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ahb_ram_arbiter;
  localparam int AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          hreset;
  logic          m0_hsel, m0_hwrite, m1_hsel, m1_hwrite;
  logic [1:0]    m0_htrans, m1_htrans;
  logic [2:0]    m0_hsize, m1_hsize;
  logic [AW-1:0] m0_haddr, m1_haddr;
  logic [31:0]   m0_hwdata, m1_hwdata;

  logic [31:0]   m0_hrdata [2];
  logic [31:0]   m1_hrdata [2];
  logic          m0_hready [2];
  logic          m1_hready [2];
  logic [1:0]    m0_hresp  [2];
  logic [1:0]    m1_hresp  [2];
  logic          s_hsel    [2];
  logic [1:0]    s_htrans  [2];
  logic          s_hwrite  [2];
  logic [2:0]    s_hsize   [2];
  logic [AW-1:0] s_haddr   [2];
  logic [31:0]   s_hwdata  [2];
  logic          s_hready_in  [2];
  logic [31:0]   s_hrdata     [2];
  logic          s_hready_out [2];
  logic [1:0]    s_hresp      [2];
  logic          stall [2];
  logic [1:0]    resp  [2];

  int total = 0;
  int bad   = 0;
  int mon   = 0;
  logic [31:0] exp0 [$];
  logic [31:0] exp1 [$];
  logic [31:0] obs0 [$];
  logic [31:0] obs1 [$];

  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ahb_ram_arbiter #(.ARB_MODE(g), .AW(AW)) dut (
      .hclk(clk), .hreset(hreset),
      .m0_hsel(m0_hsel), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite),
      .m0_hsize(m0_hsize), .m0_haddr(m0_haddr), .m0_hwdata(m0_hwdata),
      .m0_hrdata(m0_hrdata[g]), .m0_hready(m0_hready[g]), .m0_hresp(m0_hresp[g]),
      .m1_hsel(m1_hsel), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite),
      .m1_hsize(m1_hsize), .m1_haddr(m1_haddr), .m1_hwdata(m1_hwdata),
      .m1_hrdata(m1_hrdata[g]), .m1_hready(m1_hready[g]), .m1_hresp(m1_hresp[g]),
      .s_hsel(s_hsel[g]), .s_htrans(s_htrans[g]), .s_hwrite(s_hwrite[g]),
      .s_hsize(s_hsize[g]), .s_haddr(s_haddr[g]), .s_hwdata(s_hwdata[g]),
      .s_hready_in(s_hready_in[g]), .s_hrdata(s_hrdata[g]),
      .s_hready_out(s_hready_out[g]), .s_hresp(s_hresp[g])
    );
  end

  for (genvar g = 0; g < 2; g++) begin : g_slave
    logic [31:0] mem [256];
    logic        dp_v, dp_w;
    logic [7:0]  dp_a;
    always @(posedge clk) begin
      if (hreset) begin
        for (int i = 0; i < 256; i++) mem[i] <= pat(32'(i * 4));
        dp_v <= 1'b0;
        dp_w <= 1'b0;
        dp_a <= 8'h0;
      end else begin
        if (dp_v && dp_w && s_hready_out[g]) mem[dp_a] <= s_hwdata[g];
        if (s_hready_in[g]) begin
          dp_v <= s_hsel[g] & s_htrans[g][1];
          dp_w <= s_hwrite[g];
          dp_a <= s_haddr[g][9:2];
        end
      end
    end
    assign s_hrdata[g]     = dp_v ? mem[dp_a] : 32'h0;
    assign s_hready_out[g] = ~stall[g];
    assign s_hresp[g]      = resp[g];
  end

  // Records read data of completed data phases on the instance under observation.
  logic dp0 = 1'b0, dp0w = 1'b0, dp1 = 1'b0, dp1w = 1'b0;
  always @(negedge clk) begin
    if (hreset) begin
      dp0 = 1'b0;
      dp1 = 1'b0;
    end else begin
      if (dp0 && m0_hready[mon]) begin
        if (!dp0w) obs0.push_back(m0_hrdata[mon]);
        dp0 = 1'b0;
      end
      if (m0_hsel && m0_htrans[1] && m0_hready[mon]) begin
        dp0 = 1'b1;
        dp0w = m0_hwrite;
      end
      if (dp1 && m1_hready[mon]) begin
        if (!dp1w) obs1.push_back(m1_hrdata[mon]);
        dp1 = 1'b0;
      end
      if (m1_hsel && m1_htrans[1] && m1_hready[mon]) begin
        dp1 = 1'b1;
        dp1w = m1_hwrite;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    m0_hsel = 1'b0; m0_htrans = 2'b00; m0_hwrite = 1'b0;
    m1_hsel = 1'b0; m1_htrans = 2'b00; m1_hwrite = 1'b0;
  endtask

  task automatic m0_rd(input logic [31:0] a);
    m0_hsel = 1'b1; m0_htrans = 2'b10; m0_hwrite = 1'b0; m0_hsize = 3'd2; m0_haddr = a;
  endtask

  task automatic m1_rd(input logic [31:0] a);
    m1_hsel = 1'b1; m1_htrans = 2'b10; m1_hwrite = 1'b0; m1_hsize = 3'd2; m1_haddr = a;
  endtask

  task automatic do_reset();
    step(); hreset = 1'b1; idle(); stall[0] = 1'b0; stall[1] = 1'b0;
    step(); step(); hreset = 1'b0;
    exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete();
  endtask

  task automatic test_reset();
    hreset = 1'b1; idle();
    step(); step(); smp();
    for (int d = 0; d < 2; d++) begin
      total++; if (m0_hready[d] !== 1'b1) begin bad++; $display("FAIL reset_m0_hready dut%0d got=%b exp=1", d, m0_hready[d]); end
      total++; if (m1_hready[d] !== 1'b1) begin bad++; $display("FAIL reset_m1_hready dut%0d got=%b exp=1", d, m1_hready[d]); end
      total++; if (s_htrans[d] !== 2'b00) begin bad++; $display("FAIL reset_s_htrans dut%0d got=%h exp=0", d, s_htrans[d]); end
      total++; if (s_hsel[d] !== 1'b0) begin bad++; $display("FAIL reset_s_hsel dut%0d got=%b exp=0", d, s_hsel[d]); end
      total++; if (m0_hresp[d] !== 2'b00 || m1_hresp[d] !== 2'b00) begin bad++; $display("FAIL reset_hresp dut%0d got=%h/%h exp=0", d, m0_hresp[d], m1_hresp[d]); end
    end
    step(); hreset = 1'b0;
  endtask

  task automatic test_single_read();
    logic [31:0] o, e;
    mon = 0;
    step(); m0_rd(32'h100); exp0.push_back(pat(32'h100)); smp();
    total++; if (s_haddr[0] !== 32'h100) begin bad++; $display("FAIL single_s_haddr got=%h exp=100", s_haddr[0]); end
    total++; if (s_htrans[0] !== 2'b10 || s_hsel[0] !== 1'b1) begin bad++; $display("FAIL single_s_htrans got=%h sel=%b exp=2 sel=1", s_htrans[0], s_hsel[0]); end
    step(); idle(); resp[0] = 2'b01; smp();
    total++; if (m0_hready[0] !== 1'b1) begin bad++; $display("FAIL single_m0_hready got=%b exp=1", m0_hready[0]); end
    total++; if (m0_hrdata[0] !== pat(32'h100)) begin bad++; $display("FAIL single_m0_hrdata got=%h exp=%h", m0_hrdata[0], pat(32'h100)); end
    total++; if (m0_hresp[0] !== 2'b01 || m1_hresp[0] !== 2'b00) begin bad++; $display("FAIL single_hresp got=%h/%h exp=1/0", m0_hresp[0], m1_hresp[0]); end
    total++; if (m1_hready[0] !== 1'b1 || s_htrans[0] !== 2'b00) begin bad++; $display("FAIL single_m1_idle got=%b/%h exp=1/0", m1_hready[0], s_htrans[0]); end
    step(); resp[0] = 2'b00; step();
    total++; if (obs0.size() != exp0.size()) begin bad++; $display("FAIL single_sb_count got=%0d exp=%0d", obs0.size(), exp0.size()); end
    while (exp0.size() != 0 && obs0.size() != 0) begin
      o = obs0.pop_front(); e = exp0.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL single_sb_data got=%h exp=%h", o, e); end
    end
    exp0.delete(); obs0.delete();
  endtask

  task automatic test_simultaneous();
    logic [31:0] o, e;
    mon = 0;
    do_reset();
    step(); m0_rd(32'h10); exp0.push_back(pat(32'h10));
    m1_hsel = 1'b1; m1_htrans = 2'b10; m1_hwrite = 1'b1; m1_hsize = 3'd2; m1_haddr = 32'h20; smp();
    total++; if (s_haddr[0] !== 32'h20 || s_hwrite[0] !== 1'b1) begin bad++; $display("FAIL simul_m1_first got=%h w=%b exp=20 w=1", s_haddr[0], s_hwrite[0]); end
    step(); idle(); m1_hwdata = 32'hDEADBEEF; smp();
    total++; if (m0_hready[0] !== 1'b0) begin bad++; $display("FAIL simul_m0_stall got=%b exp=0", m0_hready[0]); end
    total++; if (s_haddr[0] !== 32'h10 || s_htrans[0] !== 2'b10) begin bad++; $display("FAIL simul_replay got=%h t=%h exp=10 t=2", s_haddr[0], s_htrans[0]); end
    total++; if (s_hwdata[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL simul_hwdata got=%h exp=deadbeef", s_hwdata[0]); end
    step(); smp();
    total++; if (m0_hready[0] !== 1'b1 || m0_hrdata[0] !== pat(32'h10)) begin bad++; $display("FAIL simul_m0_done got=%b %h exp=1 %h", m0_hready[0], m0_hrdata[0], pat(32'h10)); end
    step(); m1_rd(32'h20); exp1.push_back(32'hDEADBEEF);
    step(); idle(); step(); step();
    total++; if (obs0.size() != exp0.size() || obs1.size() != exp1.size()) begin bad++; $display("FAIL simul_sb_count got=%0d/%0d exp=%0d/%0d", obs0.size(), obs1.size(), exp0.size(), exp1.size()); end
    while (exp0.size() != 0 && obs0.size() != 0) begin
      o = obs0.pop_front(); e = exp0.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL simul_sb_m0 got=%h exp=%h", o, e); end
    end
    while (exp1.size() != 0 && obs1.size() != 0) begin
      o = obs1.pop_front(); e = exp1.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL simul_sb_m1 got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] a0, a1, o, e;
    logic h0, h1, fin, done0, done1, exp_w;
    int lo0, lo1;
    mon = 1;
    do_reset();
    a0 = 32'h100; a1 = 32'h200;
    step(); m0_rd(a0); m1_rd(a1); exp0.push_back(pat(a0)); exp1.push_back(pat(a1));
    lo0 = 0; lo1 = 0; fin = 1'b0; done0 = 1'b0; done1 = 1'b0; exp_w = 1'b0;
    for (int c = 0; c < 60 && !(done0 && done1); c++) begin
      smp();
      h0 = m0_hready[1]; h1 = m1_hready[1];
      if (c < 16) begin
        total++;
        if (!(s_hready_out[1] && s_htrans[1][1]) || s_haddr[1][9] !== exp_w) begin
          bad++; $display("FAIL rr_grant cyc=%0d got=M%0d exp=M%0d", c, s_haddr[1][9], exp_w);
        end
        exp_w = ~exp_w;
      end
      lo0 = h0 ? 0 : lo0 + 1;
      lo1 = h1 ? 0 : lo1 + 1;
      total++; if (lo0 > 1 || lo1 > 1) begin bad++; $display("FAIL rr_stall_run cyc=%0d got=%0d/%0d exp<=1", c, lo0, lo1); end
      step();
      if (c >= 16) fin = 1'b1;
      if (!done0 && h0) begin
        if (fin) begin m0_hsel = 1'b0; m0_htrans = 2'b00; done0 = 1'b1; end
        else begin a0 = a0 + 4; m0_haddr = a0; exp0.push_back(pat(a0)); end
      end
      if (!done1 && h1) begin
        if (fin) begin m1_hsel = 1'b0; m1_htrans = 2'b00; done1 = 1'b1; end
        else begin a1 = a1 + 4; m1_haddr = a1; exp1.push_back(pat(a1)); end
      end
    end
    total++; if (!(done0 && done1)) begin bad++; $display("FAIL rr_timeout got=%b%b exp=11", done0, done1); end
    step(); step(); step();
    total++; if (obs0.size() != exp0.size() || obs1.size() != exp1.size()) begin bad++; $display("FAIL rr_sb_count got=%0d/%0d exp=%0d/%0d", obs0.size(), obs1.size(), exp0.size(), exp1.size()); end
    while (exp0.size() != 0 && obs0.size() != 0) begin
      o = obs0.pop_front(); e = exp0.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL rr_sb_m0 got=%h exp=%h", o, e); end
    end
    while (exp1.size() != 0 && obs1.size() != 0) begin
      o = obs1.pop_front(); e = exp1.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL rr_sb_m1 got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_slave_wait();
    logic [31:0] o, e;
    mon = 0;
    do_reset();
    step(); m0_rd(32'h40); exp0.push_back(pat(32'h40)); smp();
    total++; if (s_haddr[0] !== 32'h40) begin bad++; $display("FAIL wait_first got=%h exp=40", s_haddr[0]); end
    step(); idle(); stall[0] = 1'b1; m1_rd(32'h80); exp1.push_back(pat(32'h80)); smp();
    total++; if (s_haddr[0] !== 32'h40) begin bad++; $display("FAIL wait_hold_addr got=%h exp=40", s_haddr[0]); end
    total++; if (m0_hready[0] !== 1'b0 || m1_hready[0] !== 1'b1) begin bad++; $display("FAIL wait_hready got=%b/%b exp=0/1", m0_hready[0], m1_hready[0]); end
    step(); idle(); stall[0] = 1'b0; smp();
    total++; if (m1_hready[0] !== 1'b0) begin bad++; $display("FAIL wait_pend1 got=%b exp=0", m1_hready[0]); end
    total++; if (s_haddr[0] !== 32'h80 || s_htrans[0] !== 2'b10) begin bad++; $display("FAIL wait_replay got=%h t=%h exp=80 t=2", s_haddr[0], s_htrans[0]); end
    step(); smp();
    total++; if (m1_hready[0] !== 1'b1 || m1_hrdata[0] !== pat(32'h80)) begin bad++; $display("FAIL wait_m1_done got=%b %h exp=1 %h", m1_hready[0], m1_hrdata[0], pat(32'h80)); end
    step(); step();
    total++; if (obs0.size() != exp0.size() || obs1.size() != exp1.size()) begin bad++; $display("FAIL wait_sb_count got=%0d/%0d exp=%0d/%0d", obs0.size(), obs1.size(), exp0.size(), exp1.size()); end
    while (exp0.size() != 0 && obs0.size() != 0) begin
      o = obs0.pop_front(); e = exp0.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL wait_sb_m0 got=%h exp=%h", o, e); end
    end
    while (exp1.size() != 0 && obs1.size() != 0) begin
      o = obs1.pop_front(); e = exp1.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL wait_sb_m1 got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_reset_pending();
    mon = 0;
    do_reset();
    step(); m0_rd(32'h10); m1_rd(32'h20);
    step(); idle(); hreset = 1'b1; smp();
    total++; if (m0_hready[0] !== 1'b0) begin bad++; $display("FAIL rstp_pend_setup got=%b exp=0", m0_hready[0]); end
    step(); smp();
    total++; if (m0_hready[0] !== 1'b1 || s_htrans[0] !== 2'b00 || s_hsel[0] !== 1'b0) begin bad++; $display("FAIL rstp_in_reset got=%b %h %b exp=1 0 0", m0_hready[0], s_htrans[0], s_hsel[0]); end
    step(); hreset = 1'b0; smp();
    total++; if (m0_hready[0] !== 1'b1 || m1_hready[0] !== 1'b1 || s_htrans[0] !== 2'b00) begin bad++; $display("FAIL rstp_after got=%b/%b %h exp=1/1 0", m0_hready[0], m1_hready[0], s_htrans[0]); end
    step(); smp();
    total++; if (s_htrans[0] !== 2'b00 || s_hsel[0] !== 1'b0) begin bad++; $display("FAIL rstp_no_spurious got=%h %b exp=0 0", s_htrans[0], s_hsel[0]); end
    exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete();
  endtask

  initial begin
    hreset = 1'b1;
    idle();
    m0_hsize = 3'd2; m1_hsize = 3'd2; m0_haddr = '0; m1_haddr = '0;
    m0_hwdata = 32'h0; m1_hwdata = 32'h0;
    stall[0] = 1'b0; stall[1] = 1'b0; resp[0] = 2'b00; resp[1] = 2'b00;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_round_robin();
    test_slave_wait();
    test_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
